// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM state type and legal-opcode check for alu_arbiter.
package alu_arb_pkg;

    localparam logic [2:0] OP_SUB     = 3'b111;
    localparam logic [2:0] OP_ABSDIFF = 3'b101;
    localparam logic [2:0] OP_PASSA   = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_ABSDIFF) || (op == OP_PASSA);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshakes of both clients plus the ALU operand/result bus.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_con;
    logic [WIDTH-1:0] alu_out;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, rsp_err, alu_a, alu_b, alu_con
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, rsp_err, alu_a, alu_b, alu_con
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; i_last is the requester served most recently.
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last,
    output logic o_any,
    output logic o_grant
);

    assign o_any = i_valid0 | i_valid1;

    always_comb begin
        if (i_valid0 && i_valid1) begin
            o_grant = ~i_last;
        end else begin
            o_grant = i_valid1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional grant counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
`endif
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_owner;
    logic             r_last;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_con;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic w_any;
    logic w_grant;
    logic w_accept;
    logic w_rsp_fire;
    logic w_req0_ready;
    logic w_req1_ready;
    logic w_rsp0_valid;
    logic w_rsp1_valid;

    rr_arb2 u_rr_arb2 (
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .i_last   (r_last),
        .o_any    (w_any),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rsp_fire   = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_rsp0_valid = 1'b0;
        w_rsp1_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req0_ready = w_any && !w_grant;
                w_req1_ready = w_any && w_grant;
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                w_rsp0_valid = !r_owner;
                w_rsp1_valid = r_owner;
                w_rsp_fire   = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
                if (w_rsp_fire) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_con  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner   <= w_grant;
                r_alu_a   <= w_grant ? bus.req1_a  : bus.req0_a;
                r_alu_b   <= w_grant ? bus.req1_b  : bus.req0_b;
                r_alu_con <= w_grant ? bus.req1_op : bus.req0_op;
            end
            // Illegal opcodes still run through the ALU, but the result is masked.
            if (r_state == EXEC) begin
                r_rsp_data <= is_legal_op(r_alu_con) ? bus.alu_out : '0;
                r_rsp_err  <= !is_legal_op(r_alu_con);
            end
            if (w_rsp_fire) begin
                r_last <= r_owner;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_grant && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (w_grant && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp0_valid = w_rsp0_valid;
    assign bus.rsp1_valid = w_rsp1_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_con    = r_alu_con;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural sign-magnitude ALU alongside.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gc0;
    logic [15:0] gc1;
`endif

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    logic        v   [2];
    logic [31:0] ra  [2];
    logic [31:0] rb  [2];
    logic [2:0]  rop [2];
    logic        rr  [2];

    assign bus.req0_valid = v[0];
    assign bus.req0_a     = ra[0];
    assign bus.req0_b     = rb[0];
    assign bus.req0_op    = rop[0];
    assign bus.req1_valid = v[1];
    assign bus.req1_a     = ra[1];
    assign bus.req1_b     = rb[1];
    assign bus.req1_op    = rop[1];
    assign bus.rsp0_ready = rr[0];
    assign bus.rsp1_ready = rr[1];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned last_grant = 1;
    int unsigned cnt [2];

    function automatic longint sm2i(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    function automatic logic [31:0] i2sm(input longint x);
        logic [30:0] mag;
        if (x < 0) begin
            mag = 31'(-x);
            return {1'b1, mag};
        end
        mag = 31'(x);
        return {1'b0, mag};
    endfunction

    // Stand-in for the external ALU; illegal opcodes yield junk so masking is visible.
    always_comb begin
        case (bus.alu_con)
            3'b111:  bus.alu_out = i2sm(sm2i(bus.alu_a) - sm2i(bus.alu_b));
            3'b101:  bus.alu_out = (sm2i(bus.alu_a) >= sm2i(bus.alu_b)) ?
                                   i2sm(sm2i(bus.alu_a) - sm2i(bus.alu_b)) :
                                   i2sm(sm2i(bus.alu_b) - sm2i(bus.alu_a));
            3'b100:  bus.alu_out = bus.alu_a;
            default: bus.alu_out = bus.alu_a ^ bus.alu_b ^ 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [31:0] expect_data(input logic [31:0] a, input logic [31:0] b,
                                                input logic [2:0] op);
        longint d;
        d = sm2i(a) - sm2i(b);
        if (op == 3'b111) return i2sm(d);
        if (op == 3'b101) return i2sm(d < 0 ? -d : d);
        if (op == 3'b100) return a;
        return 32'd0;
    endfunction

    function automatic logic [31:0] rnd_sm();
        logic [29:0] mag;
        logic        sgn;
        mag = 30'($urandom);
        sgn = 1'($urandom_range(0, 1));
        return {sgn, 1'b0, mag};
    endfunction

    function automatic logic [2:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 3'b111;
            1:       return 3'b101;
            2:       return 3'b100;
            default: return 3'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit keep, input int unsigned dly, output int unsigned who);
        int unsigned w;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eo;
        logic [31:0] ed;
        logic        ee;
        w = (v[0] && v[1]) ? ((last_grant == 1) ? 0 : 1) : (v[1] ? 1 : 0);
        rr[w]   = (dly == 0);
        rr[1-w] = 1'($urandom_range(0, 1));
        ea = ra[w];
        eb = rb[w];
        eo = rop[w];
        ed = expect_data(ea, eb, eo);
        ee = !(eo == 3'b111 || eo == 3'b101 || eo == 3'b100);
        @(negedge clk);
        chk("req0_ready_idle", 32'(bus.req0_ready), 32'(w == 0));
        chk("req1_ready_idle", 32'(bus.req1_ready), 32'(w == 1));
        @(posedge clk); #1;
        if (!keep) v[w] = 1'b0;
        @(negedge clk);
        chk("alu_a", bus.alu_a, ea);
        chk("alu_b", bus.alu_b, eb);
        chk("alu_con", 32'(bus.alu_con), 32'(eo));
        chk("rsp_valid_exec", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        chk("req_ready_exec", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid_resp", 32'({bus.rsp1_valid, bus.rsp0_valid}), (w == 1) ? 32'd2 : 32'd1);
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
        repeat (dly) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rsp_valid_hold", 32'({bus.rsp1_valid, bus.rsp0_valid}), (w == 1) ? 32'd2 : 32'd1);
            chk("rsp_data_hold", bus.rsp_data, ed);
            chk("req_ready_hold", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        end
        rr[w] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        rr[1] = 1'b0;
        last_grant = w;
        if (cnt[w] < 32'hFFFF) cnt[w]++;
        who = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned who;
        int unsigned exp_seq [4];
        v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;
        ra[0] = '0; rb[0] = '0; rop[0] = '0;
        ra[1] = '0; rb[1] = '0; rop[1] = '0;
        cnt[0] = 0; cnt[1] = 0;
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_con", 32'(bus.alu_con), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_grant_cnt0", 32'(gc0), 32'd0);
        chk("rst_grant_cnt1", 32'(gc1), 32'd0);
`endif
        @(posedge clk); #1;

        // Both valid from reset, continuous: 0,1,0,1
        v[0] = 1; ra[0] = 32'h1234; rb[0] = 32'h0; rop[0] = 3'b100;
        v[1] = 1; ra[1] = 32'h5678; rb[1] = 32'h0; rop[1] = 3'b100;
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 0, who);
            chk("rr_order", who, exp_seq[i]);
        end
        v[0] = 0; v[1] = 0;

        // req0 only: 10 - 3 = 7
        v[0] = 1; ra[0] = 32'd10; rb[0] = 32'd3; rop[0] = 3'b111;
        txn(1'b0, 0, who);
        chk("sub_owner", who, 32'd0);

        // Illegal opcode accepted, result forced to zero with error flag
        v[0] = 1; ra[0] = 32'd5; rb[0] = 32'd2; rop[0] = 3'b000;
        txn(1'b0, 0, who);
        chk("illegal_owner", who, 32'd0);

        // Backpressure on rsp1 while req0 waits
        v[1] = 1; ra[1] = rnd_sm(); rb[1] = rnd_sm(); rop[1] = 3'b101;
        v[0] = 1; ra[0] = rnd_sm(); rb[0] = rnd_sm(); rop[0] = 3'b111;
        txn(1'b0, 10, who);
        chk("bp_owner", who, 32'd1);
        txn(1'b0, 0, who);
        chk("bp_next_owner", who, 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", 32'(gc0), cnt[0]);
        chk("grant_cnt1", 32'(gc1), cnt[1]);
`endif

        // Reset while in EXEC drops the operation
        v[0] = 1; ra[0] = 32'd40; rb[0] = 32'd1; rop[0] = 3'b111;
        @(negedge clk);
        chk("mid_req0_ready", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        v[0] = 0;
        rr[0] = 1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_grant = 1; cnt[0] = 0; cnt[1] = 0;
        @(negedge clk);
        chk("mid_alu_con", 32'(bus.alu_con), 32'd0);
        chk("mid_rsp_data", bus.rsp_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            @(negedge clk);
        end
`ifdef ALU_ARB_STATS_EN
        chk("mid_grant_cnt0", 32'(gc0), 32'd0);
        chk("mid_grant_cnt1", 32'(gc1), 32'd0);
`endif
        @(posedge clk); #1;
        rr[0] = 0;
        v[0] = 1; ra[0] = 32'd9; rb[0] = 32'h8000_0004; rop[0] = 3'b111;
        txn(1'b0, 0, who);
        chk("post_rst_owner", who, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && ($urandom_range(0, 2) != 0)) begin
                    v[r] = 1; ra[r] = rnd_sm(); rb[r] = rnd_sm(); rop[r] = rnd_op();
                end
            end
            if (!v[0] && !v[1]) begin
                v[0] = 1; ra[0] = rnd_sm(); rb[0] = rnd_sm(); rop[0] = rnd_op();
            end
            txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), who);
        end
`ifdef ALU_ARB_STATS_EN
        chk("rand_grant_cnt0", 32'(gc0), cnt[0]);
        chk("rand_grant_cnt1", 32'(gc1), cnt[1]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
